// File: rtl/risc_ctrl_pkg.sv
// risc_ctrl_pkg: shared state, opcode and control-select encodings for the multi-cycle controller
package risc_ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
    S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_LUI, S_HALT
  } state_t;
  typedef enum logic [1:0] {CLS_ADD, CLS_ALU, CLS_BRANCH} alu_cls_t;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_BR = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_READ = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;
  localparam logic [1:0] RES_IMM = 2'b11;
  localparam logic [1:0] SRCA_PC = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1 = 2'b10;
  localparam logic [1:0] SRCB_RD2 = 2'b00;
  localparam logic [1:0] SRCB_IMM = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;
  // Only word loads/stores exist; branches lack the unsigned compares (funct3[1]=1)
  function automatic logic illegal_f3(input logic [6:0] op, input logic [2:0] f3);
    return (op == OP_R || op == OP_I) ? (f3 == 3'b001 || f3 == 3'b011 || f3 == 3'b101) :
           op == OP_BR ? f3[1] :
           (op == OP_LOAD || op == OP_STORE) ? f3 != 3'b010 : 1'b0;
  endfunction
  function automatic logic [2:0] imm_src(input logic [6:0] op);
    return op == OP_STORE ? IMM_S : op == OP_BR ? IMM_B : op == OP_JAL ? IMM_J :
           op == OP_LUI ? IMM_U : IMM_I;
  endfunction
endpackage

// File: rtl/risc_mc_controller_if.sv
// risc_mc_controller_if: datapath-facing status inputs and control outputs of the controller
interface risc_mc_controller_if;
  logic [6:0] OP;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic Zero;
  logic mem_ready;
  logic PCWrite;
  logic AdrSrc;
  logic MemWrite;
  logic IRWrite;
  logic RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ImmSrc;
  logic [2:0] ALUControl;
  logic halt;
  logic [31:0] instret;
  modport master (
    input OP, funct3, funct7, Zero, mem_ready,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
    ImmSrc, ALUControl, halt, instret
  );
  modport slave (
    output OP, funct3, funct7, Zero, mem_ready,
    input PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
    ImmSrc, ALUControl, halt, instret
  );
endinterface

// File: rtl/risc_alu_decoder.sv
// risc_alu_decoder: maps opcode/funct fields and state class to an ALU operation plus illegal flag
module risc_alu_decoder
  import risc_ctrl_pkg::*;
(
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  alu_cls_t   cls,
  output logic [2:0] alu_control,
  output logic       illegal
);
  logic [2:0] alu_f3;
  assign alu_f3 = funct3 == 3'b111 ? ALU_AND : funct3 == 3'b110 ? ALU_OR :
                  funct3 == 3'b100 ? ALU_XOR : funct3 == 3'b010 ? ALU_SLT :
                  (funct3 == 3'b000 && op == OP_R && funct7_5) ? ALU_SUB : ALU_ADD;
  assign alu_control = cls == CLS_BRANCH ? (funct3[2] ? ALU_SLT : ALU_SUB) :
                       cls == CLS_ALU ? alu_f3 : ALU_ADD;
  assign illegal = illegal_f3(op, funct3);
endmodule

// File: rtl/risc_mc_controller.sv
// risc_mc_controller: multi-cycle RV32I control FSM with wait-state stretching, halt trap and retire counter
module risc_mc_controller
  import risc_ctrl_pkg::*;
(
  input logic clk,
  input logic rst,
  risc_mc_controller_if.master bus
);
  state_t state_q, state_d;
  logic [31:0] instret_q, instret_d;
  alu_cls_t cls;
  logic [2:0] alu_ctl;
  logic illegal;
  assign cls = state_q == S_BRANCH ? CLS_BRANCH :
               (state_q == S_EXECR || state_q == S_EXECI) ? CLS_ALU : CLS_ADD;
  risc_alu_decoder u_alu_dec (
    .op(bus.OP), .funct3(bus.funct3), .funct7_5(bus.funct7[5]), .cls(cls),
    .alu_control(alu_ctl), .illegal(illegal)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: state_d = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: state_d = illegal ? S_HALT :
                          (bus.OP == OP_LOAD || bus.OP == OP_STORE) ? S_MEMADR :
                          bus.OP == OP_R ? S_EXECR : bus.OP == OP_I ? S_EXECI :
                          bus.OP == OP_BR ? S_BRANCH : bus.OP == OP_JAL ? S_JAL :
                          bus.OP == OP_LUI ? S_LUI : S_HALT;
      S_MEMADR: state_d = bus.OP == OP_LOAD ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: state_d = bus.mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: state_d = bus.mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR, S_EXECI, S_JAL: state_d = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_LUI: state_d = S_FETCH;
      default: state_d = S_HALT;
    endcase
    // Every path back to FETCH except the FETCH self-loop retires an instruction
    instret_d = (state_q != S_FETCH && state_d == S_FETCH) ? instret_q + 32'd1 : instret_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      instret_q <= instret_d;
    end
  end
  always_comb begin
    bus.PCWrite = 1'b0;
    bus.AdrSrc = 1'b0;
    bus.MemWrite = 1'b0;
    bus.IRWrite = 1'b0;
    bus.RegWrite = 1'b0;
    bus.ResultSrc = RES_ALUOUT;
    bus.ALUSrcA = SRCA_PC;
    bus.ALUSrcB = SRCB_RD2;
    bus.ImmSrc = IMM_I;
    bus.ALUControl = ALU_ADD;
    bus.halt = 1'b0;
    if (rst) begin
      bus.ImmSrc = imm_src(bus.OP);
      bus.ALUControl = alu_ctl;
      bus.halt = state_q == S_HALT;
      case (state_q)
        S_FETCH: begin
          bus.ALUSrcB = SRCB_FOUR;
          bus.ResultSrc = RES_ALURES;
          bus.IRWrite = bus.mem_ready;
          bus.PCWrite = bus.mem_ready;
        end
        S_DECODE: begin
          bus.ALUSrcA = SRCA_OLDPC;
          bus.ALUSrcB = SRCB_IMM;
        end
        S_MEMADR: begin
          bus.ALUSrcA = SRCA_RD1;
          bus.ALUSrcB = SRCB_IMM;
        end
        S_MEMREAD: bus.AdrSrc = 1'b1;
        S_MEMWB: begin
          bus.ResultSrc = RES_READ;
          bus.RegWrite = 1'b1;
        end
        S_MEMWRITE: begin
          bus.AdrSrc = 1'b1;
          bus.MemWrite = 1'b1;
        end
        S_EXECR: bus.ALUSrcA = SRCA_RD1;
        S_EXECI: begin
          bus.ALUSrcA = SRCA_RD1;
          bus.ALUSrcB = SRCB_IMM;
        end
        S_ALUWB: bus.RegWrite = 1'b1;
        // beq/bge take on Zero, bne/blt on !Zero
        S_BRANCH: begin
          bus.ALUSrcA = SRCA_RD1;
          bus.PCWrite = bus.Zero ^ bus.funct3[0] ^ bus.funct3[2];
        end
        S_JAL: begin
          bus.ALUSrcA = SRCA_OLDPC;
          bus.ALUSrcB = SRCB_FOUR;
          bus.PCWrite = 1'b1;
        end
        S_LUI: begin
          bus.ResultSrc = RES_IMM;
          bus.RegWrite = 1'b1;
        end
        default: ;
      endcase
    end
  end
  assign bus.instret = instret_q;
endmodule

// File: tb/tb_risc_mc_controller.sv
// tb_risc_mc_controller: directed plus randomized instruction sequences checked against a per-instruction model
module tb_risc_mc_controller;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  int exp_instret = 0;
  risc_mc_controller_if bus ();
  risc_mc_controller dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011, IT = 7'b0010011;
  localparam logic [6:0] BR = 7'b1100011, JL = 7'b1101111, LU = 7'b0110111, JALR = 7'b1100111;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_alu(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    if (op == BR) return (f3 == 3'd4 || f3 == 3'd5) ? 5 : 1;
    case (f3)
      3'd0: return (op == RT && f7[5]) ? 1 : 0;
      3'd7: return 2;
      3'd6: return 3;
      3'd4: return 4;
      default: return 5;
    endcase
  endfunction

  function automatic bit taken(input logic [2:0] f3, input logic z);
    case (f3)
      3'd0: return z;
      3'd1: return !z;
      3'd4: return !z;
      default: return z;
    endcase
  endfunction

  // Starts just after a posedge with the DUT in FETCH; returns after the retiring edge
  task automatic run_instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic z, input int fw, input int mw);
    bit is_mem = (op == LW || op == SW);
    int lat = -1, rw = 0, rs = -1, pcw = 0, irw = 0, mwc = 0, adr_bad = 0, alu = -1, imm = -1;
    int e_lat, e_imm;
    logic [31:0] i0 = bus.instret;
    bus.OP = op; bus.funct3 = f3; bus.funct7 = f7; bus.Zero = z;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      bus.mem_ready = k < fw ? 1'b0 : (is_mem && k >= fw + 3 && k < fw + 3 + mw) ? 1'b0 :
                      (is_mem || k == fw) ? 1'b1 : 1'($urandom);
      #1;
      rw += int'(bus.RegWrite);
      if (bus.RegWrite) rs = int'(bus.ResultSrc);
      pcw += int'(bus.PCWrite);
      irw += int'(bus.IRWrite);
      if (bus.MemWrite) begin
        mwc++;
        if (!bus.AdrSrc) adr_bad++;
      end
      if (k == fw + 1) imm = int'(bus.ImmSrc);
      if (k == fw + 2) alu = int'(bus.ALUControl);
      @(posedge clk);
      #1;
      if (bus.instret != i0) begin
        lat = k + 1;
        break;
      end
    end
    exp_instret++;
    e_lat = fw + (op == LW ? 5 + mw : op == SW ? 4 + mw : (op == BR || op == LU) ? 3 : 4);
    e_imm = op == SW ? 1 : op == BR ? 2 : op == JL ? 3 : op == LU ? 4 : 0;
    chk({tag, "_latency"}, lat, e_lat);
    chk({tag, "_instret"}, bus.instret, exp_instret);
    chk({tag, "_regwrites"}, rw, (op == SW || op == BR) ? 0 : 1);
    if (op != SW && op != BR) chk({tag, "_resultsrc"}, rs, op == LW ? 1 : op == LU ? 3 : 0);
    chk({tag, "_pcwrites"}, pcw, 1 + int'(op == JL) + int'(op == BR && taken(f3, z)));
    chk({tag, "_irwrites"}, irw, 1);
    chk({tag, "_memwrites"}, mwc, op == SW ? mw + 1 : 0);
    chk({tag, "_adrsrc_bad"}, adr_bad, 0);
    chk({tag, "_immsrc"}, imm, e_imm);
    if (op == RT || op == IT || op == BR) chk({tag, "_alu"}, alu, exp_alu(op, f3, f7));
  endtask

  // Starts just after a posedge; leaves the DUT in FETCH just after a posedge
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b0;
    bus.OP = SW; bus.mem_ready = 1'b1; bus.Zero = 1'b1;
    #1;
    chk({tag, "_outs_in_rst"}, {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite,
        bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.ALUControl, bus.halt}, 0);
    @(posedge clk);
    #1;
    chk({tag, "_instret_zero"}, bus.instret, 0);
    @(negedge clk);
    rst = 1'b1;
    bus.mem_ready = 1'b0;
    #1;
    chk({tag, "_fetch_sig"}, {bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.AdrSrc}, 7'b00_10_10_0);
    chk({tag, "_no_regwrite"}, bus.RegWrite, 0);
    chk({tag, "_halt_clear"}, bus.halt, 0);
    exp_instret = 0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] alu_f3s [5] = '{3'd0, 3'd7, 3'd6, 3'd4, 3'd2};
    logic [2:0] br_f3s [4] = '{3'd0, 3'd1, 3'd4, 3'd5};
    logic [31:0] i0;
    int en, hc, c;
    bus.OP = '0; bus.funct3 = '0; bus.funct7 = '0; bus.Zero = 1'b0; bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset("init");
    run_instr("lw0", LW, 3'd2, 7'd0, 1'b0, 0, 0);
    // Abort a load stuck in MEMREAD
    bus.OP = LW; bus.funct3 = 3'd2;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.mem_ready = k < 3;
      @(posedge clk);
      #1;
    end
    do_reset("mid_memread");
    run_instr("lw", LW, 3'd2, 7'd0, 1'b0, 0, 0);
    run_instr("sub", RT, 3'd0, 7'b0100000, 1'b0, 0, 0);
    run_instr("bne_z1", BR, 3'd1, 7'd0, 1'b1, 0, 0);
    run_instr("bne_z0", BR, 3'd1, 7'd0, 1'b0, 0, 0);
    run_instr("bge_z1", BR, 3'd5, 7'd0, 1'b1, 0, 0);
    run_instr("sw_wait3", SW, 3'd2, 7'd0, 1'b0, 0, 3);
    run_instr("jal", JL, 3'd3, 7'd5, 1'b0, 1, 0);
    run_instr("lui", LU, 3'd6, 7'd9, 1'b0, 2, 0);
    for (int n = 0; n < 40; n++) begin
      c = $urandom_range(0, 6);
      case (c)
        0: run_instr("rnd_lw", LW, 3'd2, 7'($urandom), 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
        1: run_instr("rnd_sw", SW, 3'd2, 7'($urandom), 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
        2: run_instr("rnd_r", RT, alu_f3s[$urandom_range(0, 4)], 7'($urandom), 1'($urandom), $urandom_range(0, 2), 0);
        3: run_instr("rnd_i", IT, alu_f3s[$urandom_range(0, 4)], 7'($urandom), 1'($urandom), $urandom_range(0, 2), 0);
        4: run_instr("rnd_br", BR, br_f3s[$urandom_range(0, 3)], 7'($urandom), 1'($urandom), $urandom_range(0, 2), 0);
        5: run_instr("rnd_jal", JL, 3'($urandom), 7'($urandom), 1'($urandom), $urandom_range(0, 2), 0);
        default: run_instr("rnd_lui", LU, 3'($urandom), 7'($urandom), 1'($urandom), $urandom_range(0, 2), 0);
      endcase
    end
    // Unsupported opcode and an unsupported R-type funct3 must both trap
    for (int t = 0; t < 2; t++) begin
      i0 = bus.instret;
      bus.OP = t == 0 ? JALR : RT;
      bus.funct3 = t == 0 ? 3'd0 : 3'd1;
      en = 0;
      hc = 0;
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        bus.mem_ready = k < 2 ? 1'b1 : 1'($urandom);
        bus.Zero = 1'($urandom);
        #1;
        if (k >= 2) begin
          en += int'(bus.PCWrite | bus.MemWrite | bus.IRWrite | bus.RegWrite);
          hc += int'(bus.halt);
        end
        @(posedge clk);
        #1;
      end
      chk(t == 0 ? "jalr_halt_cycles" : "badf3_halt_cycles", hc, 10);
      chk(t == 0 ? "jalr_no_enables" : "badf3_no_enables", en, 0);
      chk(t == 0 ? "jalr_instret" : "badf3_instret", bus.instret, i0);
      do_reset(t == 0 ? "after_jalr" : "after_badf3");
    end
    run_instr("post_halt_addi", IT, 3'd0, 7'b0100000, 1'b0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/risc_mc_controller.md
# risc_mc_controller

Multi-cycle main controller for the RV32I core. It sequences a shared-memory datapath (one memory port for instruction and data, IR/OldPC/ALUOut registers) through fetch, decode, execute, memory and writeback states, one instruction at a time. It stretches memory states on wait-states and halts on unsupported instructions. It sits beside the datapath, taking `OP`/`funct3`/`funct7`/`Zero` from it and driving all of its enables and mux selects.

## Interface
Parameters:
- none (all encodings come from `risc_ctrl_pkg`)

Ports:
- `clk`  in  1  core clock; all state changes on rising edge
- `rst`  in  1  synchronous, active-low reset
- `OP`  in  7  opcode from the IR
- `funct3`  in  3  IR[14:12]
- `funct7`  in  7  IR[31:25]; only bit 5 is used
- `Zero`  in  1  ALU zero flag
- `mem_ready`  in  1  memory completes the current access this cycle
- `PCWrite`  out  1  PC register load enable
- `AdrSrc`  out  1  memory address select: 0 = PC, 1 = Result
- `MemWrite`  out  1  memory write enable
- `IRWrite`  out  1  IR and OldPC load enable
- `RegWrite`  out  1  register file write enable
- `ResultSrc`  out  2  00 ALUOut, 01 ReadData, 10 ALUResult, 11 ImmExt
- `ALUSrcA`  out  2  00 PC, 01 OldPC, 10 RD1
- `ALUSrcB`  out  2  00 RD2, 01 ImmExt, 10 constant 4
- `ImmSrc`  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- `ALUControl`  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt
- `halt`  out  1  sticky: an illegal instruction was decoded
- `instret`  out  32  count of retired instructions

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, LUI, HALT.
- Any output not listed for a state is 0. `ImmSrc` is decoded from `OP` in every state.

State actions and transitions:
- **FETCH:** AdrSrc=0; ALUSrcA=00; ALUSrcB=10; add; ResultSrc=10; IRWrite=PCWrite=`mem_ready`. Stay while `!mem_ready`, otherwise go to DECODE.
- **DECODE:** ALUSrcA=01, ALUSrcB=01, add (precomputes the branch/JAL target).
  - lw (0000011) or sw (0100011) → MEMADR
  - R (0110011) → EXECR
  - I-ALU (0010011) → EXECI
  - branch (1100011) → BRANCH
  - jal (1101111) → JAL
  - lui (0110111) → LUI
  - anything else, or an unsupported funct3 → HALT
- **MEMADR:** ALUSrcA=10, ALUSrcB=01, add. Go to MEMREAD for lw, MEMWRITE for sw.
- **MEMREAD:** AdrSrc=1, ResultSrc=00. Wait for `mem_ready`, then go to MEMWB.
- **MEMWB:** ResultSrc=01, RegWrite=1. Go to FETCH.
- **MEMWRITE:** AdrSrc=1, ResultSrc=00, MemWrite=1 held until the `mem_ready` cycle. Go to FETCH.
- **EXECR / EXECI:** ALUSrcA=10; ALUSrcB=00 (EXECR) or 01 (EXECI); ALUControl from the ALU decoder. Go to ALUWB.
- **ALUWB:** ResultSrc=00, RegWrite=1. Go to FETCH.
- **BRANCH:** ALUSrcA=10, ALUSrcB=00, ResultSrc=00.
  - beq/bne use sub; blt/bge use slt.
  - PCWrite = Zero for beq and bge; PCWrite = !Zero for bne and blt.
  - Other funct3 values were already trapped in DECODE. Go to FETCH.
- **JAL:** ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1. Go to ALUWB.
- **LUI:** ResultSrc=11, RegWrite=1. Go to FETCH.
- **HALT:** all enables 0, `halt`=1. Only reset exits this state.

ALU decode, with funct3 mapping identical for R and I:
- funct3 000: add; sub only when R-type and `funct7[5]`=1
- funct3 111: and
- funct3 110: or
- funct3 100: xor
- funct3 010: slt
- all other funct3 values are illegal

Retire counter:
- `instret` increments in the cycle the FSM returns to FETCH from MEMWB, MEMWRITE (on `mem_ready`), ALUWB, BRANCH or LUI.
- It wraps from 0xFFFFFFFF to 0 and does not count in HALT.

## Timing
- Reset (`rst`=0 at an edge), whether idle or mid-instruction: the next state is FETCH, `instret`=0 and `halt`=0.
- While `rst` is low, all enables are 0 and selects are 0.
- The first FETCH is the cycle after `rst` rises.
- Latency in cycles with `mem_ready` tied high:
  - lw 5
  - sw 4
  - R, I and jal 4
  - branch and lui 3
- Each cycle with `mem_ready`=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- A write enable is never asserted for more than one cycle, except MemWrite during a wait.
- Control outputs are combinational from the state plus `OP`/`funct3`/`funct7`/`Zero`/`mem_ready`. There are no glitch requirements beyond a single clock.

## Structure
- `risc_ctrl_pkg` holds:
  - the state enum
  - opcode constants
  - ALUControl, ImmSrc, ResultSrc, ALUSrcA and ALUSrcB encodings
  - the illegal-funct3 predicate
- Sub-module `risc_alu_decoder` is combinational: it maps (`OP`, `funct3`, `funct7[5]`, state class) to ALUControl plus an illegal flag.
- The FSM, output decode and `instret` counter live in `risc_mc_controller`.

## Test plan
- Reset mid-MEMREAD with `mem_ready`=0, then release: FETCH in the first cycle, `instret`=0, no RegWrite pulse.
- `lw` (OP 0000011) with `mem_ready` high: states FETCH→DECODE→MEMADR→MEMREAD→MEMWB. Exactly one RegWrite with ResultSrc=01, and `instret` goes 0→1.
- `sub` (OP 0110011, funct3 000, funct7 0100000): ALUControl=001 in EXECR, RegWrite in ALUWB, 4 cycles.
- Branches:
  - `bne` with Zero=1: PCWrite=0 in BRANCH.
  - `bne` with Zero=0: PCWrite=1.
  - `bge` with Zero=1: ALUControl=101 and PCWrite=1.
- `sw` with `mem_ready` low for 3 cycles in MEMWRITE: MemWrite is high for 4 consecutive cycles and AdrSrc=1 throughout. Total sw latency is 7 cycles.
- OP 1100111 (jalr, unsupported): HALT after DECODE, `halt`=1, no enables for 10 cycles, `instret` unchanged. Reset clears `halt`.
